// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit.
// Holds the FSM state enum, funct3 encodings and the funct3 legality check.
package lsu_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        STORE  = 3'd2,
        RMW_RD = 3'd3,
        RMW_WR = 3'd4,
        RESP   = 3'd5
    } lsu_state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Stores only have signed-width encodings; loads add the unsigned ones.
    function automatic logic is_legal_funct3(input logic we, input logic [2:0] f3);
        logic ok;
        ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
        if (!we) begin
            ok = ok || (f3 == F3_BU) || (f3 == F3_HU);
        end
        return ok;
    endfunction

endpackage

// File: rtl/lsu_byte_lane.sv
// Byte-lane datapath: load extract/extend and store merge within a word.
// Ports: word (memory word), wdata (right-aligned store data), offset
// (byte offset), funct3 (access type) -> rdata (extended load), merged.
module lsu_byte_lane
    import lsu_pkg::*;
#(
    parameter int WORD_WIDTH = 32
) (
    input  logic [WORD_WIDTH-1:0] word,
    input  logic [WORD_WIDTH-1:0] wdata,
    input  logic [1:0]            offset,
    input  logic [2:0]            funct3,
    output logic [WORD_WIDTH-1:0] rdata,
    output logic [WORD_WIDTH-1:0] merged
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;
    logic [4:0]  b_pos;
    logic [4:0]  h_pos;

    always_comb begin
        b_pos  = {offset, 3'b000};
        h_pos  = {offset[1], 4'b0000};
        lane_b = word[b_pos +: 8];
        lane_h = word[h_pos +: 16];

        case (funct3)
            F3_B:    rdata = {{(WORD_WIDTH-8){lane_b[7]}}, lane_b};
            F3_BU:   rdata = {{(WORD_WIDTH-8){1'b0}}, lane_b};
            F3_H:    rdata = {{(WORD_WIDTH-16){lane_h[15]}}, lane_h};
            F3_HU:   rdata = {{(WORD_WIDTH-16){1'b0}}, lane_h};
            default: rdata = word;
        endcase

        merged = word;
        case (funct3[1:0])
            2'b00:   merged[b_pos +: 8]  = wdata[7:0];
            2'b01:   merged[h_pos +: 16] = wdata[15:0];
            default: merged = wdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: issues one CPU load or store at a time to a word-aligned
// data memory, with lane select, sign/zero extend and read-modify-write.
// Ports: req_* (request handshake), resp_* (response handshake),
// mem_a/mem_wd/mem_we (memory drive), mem_rd (combinational read data).
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int                       ADDRESS_WIDTH = 32,
    parameter int                       WORD_WIDTH    = 32,
    parameter logic [ADDRESS_WIDTH-1:0] MEM_TOP       = 32'h0001FFFF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_we,
    input  logic [2:0]               req_funct3,
    input  logic [ADDRESS_WIDTH-1:0] req_addr,
    input  logic [WORD_WIDTH-1:0]    req_wdata,
    output logic                     resp_valid,
    input  logic                     resp_ready,
    output logic [WORD_WIDTH-1:0]    resp_rdata,
    output logic                     resp_fault,
    output logic [ADDRESS_WIDTH-1:0] mem_a,
    output logic [WORD_WIDTH-1:0]    mem_wd,
    output logic                     mem_we,
    input  logic [WORD_WIDTH-1:0]    mem_rd
);

    // Highest legal word-aligned address.
    localparam logic [ADDRESS_WIDTH-1:0] AW_TOP = MEM_TOP - ADDRESS_WIDTH'(3);

    lsu_state_t              state_q, state_d;
    logic [ADDRESS_WIDTH-1:0] mem_a_q, mem_a_d;
    logic [WORD_WIDTH-1:0]    mem_wd_q, mem_wd_d;
    logic [WORD_WIDTH-1:0]    resp_rdata_q, resp_rdata_d;
    logic                     resp_fault_q, resp_fault_d;
    logic [2:0]               f3_q, f3_d;
    logic [1:0]               off_q, off_d;
    logic [WORD_WIDTH-1:0]    wdata_q, wdata_d;

    logic [ADDRESS_WIDTH-1:0] aw;
    logic                     fault;
    logic [WORD_WIDTH-1:0]    lane_rdata;
    logic [WORD_WIDTH-1:0]    lane_merged;

    lsu_byte_lane #(
        .WORD_WIDTH (WORD_WIDTH)
    ) u_lane (
        .word   (mem_rd),
        .wdata  (wdata_q),
        .offset (off_q),
        .funct3 (f3_q),
        .rdata  (lane_rdata),
        .merged (lane_merged)
    );

    always_comb begin
        aw    = {req_addr[ADDRESS_WIDTH-1:2], 2'b00};
        fault = !is_legal_funct3(req_we, req_funct3);
        if (req_funct3[1:0] == 2'b01 && req_addr[0]) begin
            fault = 1'b1;
        end
        if (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00) begin
            fault = 1'b1;
        end
        if (aw > AW_TOP) begin
            fault = 1'b1;
        end
    end

    always_comb begin
        state_d      = state_q;
        mem_a_d      = mem_a_q;
        mem_wd_d     = mem_wd_q;
        resp_rdata_d = resp_rdata_q;
        resp_fault_d = resp_fault_q;
        f3_d         = f3_q;
        off_d        = off_q;
        wdata_d      = wdata_q;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    f3_d         = req_funct3;
                    off_d        = req_addr[1:0];
                    wdata_d      = req_wdata;
                    resp_rdata_d = '0;
                    resp_fault_d = fault;
                    // A faulting request never touches mem_a or memory.
                    if (fault) begin
                        state_d = RESP;
                    end else if (!req_we) begin
                        state_d = LOAD;
                        mem_a_d = aw;
                    end else if (req_funct3 == F3_W) begin
                        state_d  = STORE;
                        mem_a_d  = aw;
                        mem_wd_d = req_wdata;
                    end else begin
                        state_d = RMW_RD;
                        mem_a_d = aw;
                    end
                end
            end
            LOAD: begin
                resp_rdata_d = lane_rdata;
                state_d      = RESP;
            end
            STORE: begin
                state_d = RESP;
            end
            RMW_RD: begin
                // Merge straight from the read word; no separate old-word flop.
                mem_wd_d = lane_merged;
                state_d  = RMW_WR;
            end
            RMW_WR: begin
                state_d = RESP;
            end
            RESP: begin
                if (resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            mem_a_q      <= '0;
            mem_wd_q     <= '0;
            resp_rdata_q <= '0;
            resp_fault_q <= 1'b0;
            f3_q         <= 3'b000;
            off_q        <= 2'b00;
            wdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            mem_a_q      <= mem_a_d;
            mem_wd_q     <= mem_wd_d;
            resp_rdata_q <= resp_rdata_d;
            resp_fault_q <= resp_fault_d;
            f3_q         <= f3_d;
            off_q        <= off_d;
            wdata_q      <= wdata_d;
        end
    end

    assign req_ready  = (state_q == IDLE);
    assign resp_valid = (state_q == RESP);
    assign resp_rdata = resp_rdata_q;
    assign resp_fault = resp_fault_q;
    assign mem_a      = mem_a_q;
    assign mem_wd     = mem_wd_q;
    // Reset gates the strobe so a write in flight never lands.
    assign mem_we     = ((state_q == STORE) || (state_q == RMW_WR)) && !rst;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed testbench for load_store_unit with a word-addressed memory model.
// Each scenario task drives stimulus and compares outputs inline.
module tb_load_store_unit;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_fault;
    logic [31:0] mem_a;
    logic [31:0] mem_wd;
    logic        mem_we;
    logic [31:0] mem_rd;

    logic [31:0] dmem [0:32767];
    int          wr_cnt;
    int          pass_cnt;
    int          total_cnt;

    load_store_unit dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_fault (resp_fault),
        .mem_a      (mem_a),
        .mem_wd     (mem_wd),
        .mem_we     (mem_we),
        .mem_rd     (mem_rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_rd = dmem[mem_a[16:2]];

    always @(posedge clk) begin
        if (mem_we) begin
            dmem[mem_a[16:2]] <= mem_wd;
            wr_cnt <= wr_cnt + 1;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
        else pass_cnt++;
    endtask

    // Drive one request through its accepting edge, then scramble req_*.
    task automatic issue(input logic we, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wd);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wd;
        step();
        req_valid  = 1'b0;
        req_we     = ~we;
        req_funct3 = 3'b111;
        req_addr   = 32'hDEAD_BEE1;
        req_wdata  = 32'h5555_5555;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        #1;
        total_cnt++;
        if (resp_valid !== 1'b0) $display("FAIL rst_resp_valid: got %b expected 0", resp_valid);
        else pass_cnt++;
        total_cnt++;
        if (req_ready !== 1'b1) $display("FAIL rst_req_ready: got %b expected 1", req_ready);
        else pass_cnt++;
        total_cnt++;
        if (resp_rdata !== 32'h0) $display("FAIL rst_rdata: got %h expected 0", resp_rdata);
        else pass_cnt++;
        total_cnt++;
        if (resp_fault !== 1'b0) $display("FAIL rst_fault: got %b expected 0", resp_fault);
        else pass_cnt++;
        total_cnt++;
        if (mem_a !== 32'h0) $display("FAIL rst_mem_a: got %h expected 0", mem_a);
        else pass_cnt++;
        total_cnt++;
        if (mem_wd !== 32'h0) $display("FAIL rst_mem_wd: got %h expected 0", mem_wd);
        else pass_cnt++;
        total_cnt++;
        if (mem_we !== 1'b0) $display("FAIL rst_mem_we: got %b expected 0", mem_we);
        else pass_cnt++;
    endtask

    task automatic test_lw();
        int w0;
        w0 = wr_cnt;
        issue(1'b0, 3'b010, 32'h0001_0000, 32'h0);
        total_cnt++;
        if (resp_valid !== 1'b0) $display("FAIL lw_early_valid: got %b expected 0", resp_valid);
        else pass_cnt++;
        total_cnt++;
        if (mem_a !== 32'h0001_0000) $display("FAIL lw_mem_a: got %h expected 00010000", mem_a);
        else pass_cnt++;
        total_cnt++;
        if (mem_we !== 1'b0) $display("FAIL lw_mem_we: got %b expected 0", mem_we);
        else pass_cnt++;
        step();
        total_cnt++;
        if (resp_valid !== 1'b1) $display("FAIL lw_valid: got %b expected 1", resp_valid);
        else pass_cnt++;
        total_cnt++;
        if (resp_rdata !== 32'h8081_F2F3) $display("FAIL lw_rdata: got %h expected 8081f2f3", resp_rdata);
        else pass_cnt++;
        total_cnt++;
        if (resp_fault !== 1'b0) $display("FAIL lw_fault: got %b expected 0", resp_fault);
        else pass_cnt++;
        step();
        total_cnt++;
        if (req_ready !== 1'b1) $display("FAIL lw_idle: got %b expected 1", req_ready);
        else pass_cnt++;
        total_cnt++;
        if (wr_cnt !== w0) $display("FAIL lw_no_write: got %0d expected %0d", wr_cnt, w0);
        else pass_cnt++;
    endtask

    task automatic test_load_ext();
        logic [2:0]  f3  [4] = '{3'b000, 3'b100, 3'b001, 3'b101};
        logic [31:0] ad  [4] = '{32'h10002, 32'h10002, 32'h10002, 32'h10000};
        logic [31:0] exp [4] = '{32'hFFFF_FF81, 32'h0000_0081, 32'hFFFF_8081, 32'h0000_F2F3};
        for (int i = 0; i < 4; i++) begin
            issue(1'b0, f3[i], ad[i], 32'h0);
            total_cnt++;
            if (mem_a !== 32'h0001_0000)
                $display("FAIL ext%0d_mem_a: got %h expected 00010000", i, mem_a);
            else pass_cnt++;
            step();
            total_cnt++;
            if (resp_valid !== 1'b1 || resp_rdata !== exp[i])
                $display("FAIL ext%0d_rdata: got v=%b %h expected v=1 %h", i, resp_valid, resp_rdata, exp[i]);
            else pass_cnt++;
            step();
        end
    endtask

    task automatic test_sb_rmw();
        issue(1'b1, 3'b000, 32'h0001_0001, 32'h1234_56AA);
        total_cnt++;
        if (mem_we !== 1'b0 || resp_valid !== 1'b0)
            $display("FAIL sb_rd_cycle: got we=%b v=%b expected we=0 v=0", mem_we, resp_valid);
        else pass_cnt++;
        step();
        total_cnt++;
        if (mem_we !== 1'b1) $display("FAIL sb_we: got %b expected 1", mem_we);
        else pass_cnt++;
        total_cnt++;
        if (mem_a !== 32'h0001_0000) $display("FAIL sb_mem_a: got %h expected 00010000", mem_a);
        else pass_cnt++;
        total_cnt++;
        if (mem_wd !== 32'h8081_AAF3) $display("FAIL sb_mem_wd: got %h expected 8081aaf3", mem_wd);
        else pass_cnt++;
        step();
        total_cnt++;
        if (resp_valid !== 1'b1 || resp_fault !== 1'b0 || resp_rdata !== 32'h0)
            $display("FAIL sb_resp: got v=%b f=%b %h expected v=1 f=0 0", resp_valid, resp_fault, resp_rdata);
        else pass_cnt++;
        step();
        issue(1'b0, 3'b010, 32'h0001_0000, 32'h0);
        step();
        total_cnt++;
        if (resp_rdata !== 32'h8081_AAF3) $display("FAIL sb_readback: got %h expected 8081aaf3", resp_rdata);
        else pass_cnt++;
        step();
        // Restore the original word through the SW path.
        issue(1'b1, 3'b010, 32'h0001_0000, 32'h8081_F2F3);
        total_cnt++;
        if (mem_we !== 1'b1 || mem_wd !== 32'h8081_F2F3)
            $display("FAIL sw_drive: got we=%b %h expected we=1 8081f2f3", mem_we, mem_wd);
        else pass_cnt++;
        step();
        total_cnt++;
        if (resp_valid !== 1'b1 || dmem[16'h4000] !== 32'h8081_F2F3)
            $display("FAIL sw_resp: got v=%b mem=%h expected v=1 8081f2f3", resp_valid, dmem[16'h4000]);
        else pass_cnt++;
        step();
    endtask

    task automatic test_faults();
        logic        we [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
        logic [2:0]  f3 [4] = '{3'b010, 3'b001, 3'b010, 3'b011};
        logic [31:0] ad [4] = '{32'h10002, 32'h10001, 32'h20000, 32'h10000};
        int w0;
        for (int i = 0; i < 4; i++) begin
            w0 = wr_cnt;
            issue(we[i], f3[i], ad[i], 32'hCAFE_F00D);
            total_cnt++;
            if (resp_valid !== 1'b1 || resp_fault !== 1'b1 || resp_rdata !== 32'h0)
                $display("FAIL fault%0d_resp: got v=%b f=%b %h expected v=1 f=1 0", i, resp_valid, resp_fault, resp_rdata);
            else pass_cnt++;
            total_cnt++;
            if (mem_we !== 1'b0) $display("FAIL fault%0d_we: got %b expected 0", i, mem_we);
            else pass_cnt++;
            step();
            total_cnt++;
            if (wr_cnt !== w0 || dmem[16'h4000] !== 32'h8081_F2F3)
                $display("FAIL fault%0d_mem: got writes=%0d mem=%h expected writes=%0d 8081f2f3", i, wr_cnt, dmem[16'h4000], w0);
            else pass_cnt++;
        end
    endtask

    task automatic test_backpressure();
        int w0;
        w0 = wr_cnt;
        resp_ready = 1'b0;
        issue(1'b0, 3'b010, 32'h0001_0000, 32'h0);
        step();
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin
                req_valid  = 1'b1;
                req_we     = 1'b1;
                req_funct3 = 3'b010;
                req_addr   = 32'h0001_0004;
                req_wdata  = 32'h1111_1111;
            end
            total_cnt++;
            if (resp_valid !== 1'b1 || resp_rdata !== 32'h8081_F2F3 || req_ready !== 1'b0)
                $display("FAIL bp_hold%0d: got v=%b %h rdy=%b expected v=1 8081f2f3 rdy=0", i, resp_valid, resp_rdata, req_ready);
            else pass_cnt++;
            step();
            req_valid = 1'b0;
        end
        resp_ready = 1'b1;
        step();
        total_cnt++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1)
            $display("FAIL bp_release: got v=%b rdy=%b expected v=0 rdy=1", resp_valid, req_ready);
        else pass_cnt++;
        step();
        total_cnt++;
        if (req_ready !== 1'b1 || wr_cnt !== w0)
            $display("FAIL bp_no_accept: got rdy=%b writes=%0d expected rdy=1 writes=%0d", req_ready, wr_cnt, w0);
        else pass_cnt++;
    endtask

    task automatic test_rst_rmw();
        int w0;
        w0 = wr_cnt;
        issue(1'b1, 3'b001, 32'h0001_0000, 32'h0000_BEEF);
        step();
        rst = 1'b1;
        #1;
        total_cnt++;
        if (mem_we !== 1'b0) $display("FAIL rstrmw_we: got %b expected 0", mem_we);
        else pass_cnt++;
        step();
        rst = 1'b0;
        #1;
        total_cnt++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1)
            $display("FAIL rstrmw_idle: got v=%b rdy=%b expected v=0 rdy=1", resp_valid, req_ready);
        else pass_cnt++;
        total_cnt++;
        if (dmem[16'h4000] !== 32'h8081_F2F3 || wr_cnt !== w0)
            $display("FAIL rstrmw_mem: got %h writes=%0d expected 8081f2f3 writes=%0d", dmem[16'h4000], wr_cnt, w0);
        else pass_cnt++;
    endtask

    initial begin
        pass_cnt   = 0;
        total_cnt  = 0;
        wr_cnt     = 0;
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_funct3 = 3'b000;
        req_addr   = 32'h0;
        req_wdata  = 32'h0;
        resp_ready = 1'b1;
        for (int i = 0; i < 32768; i++) dmem[i] = 32'h0;
        dmem[16'h4000] = 32'h8081_F2F3;
        #1;
        test_reset();
        test_lw();
        test_load_ext();
        test_sb_rmw();
        test_faults();
        test_backpressure();
        test_rst_rmw();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
